// File: rtl/nios2_system_v0_pll_reset_sequencer.sv
// PLL reset/lock sequencer on the reference clock: pulses the PLL reset, qualifies lock and releases sys_reset.
// Optional lock-loss event counter built when PLL_SEQ_LOCK_LOSS_COUNTER_EN is defined.
module nios2_system_v0_pll_reset_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_count
);

  localparam int MAX_AB = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES
                                                                    : LOCK_STABLE_CYCLES;
  localparam int MAX_P  = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W  = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LOAD = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       RETRY_LIM = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d, retry_inc;
  logic             sync1_q, lock_s_q;
  logic             pll_rst_q, sys_reset_q, ready_q, fault_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    retry_inc = retry_q + 4'd1;
    if (relock_req) begin
      state_d = S_RESET_PLL;
      cnt_d   = RST_LOAD;
      retry_d = 4'd0;
    end else begin
      case (state_q)
        S_RESET_PLL: begin
          if (cnt_q == '0) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = TO_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_WAIT_LOCK: begin
          // Lock wins over a timeout landing on the same cycle.
          if (lock_s_q) begin
            state_d = S_STABLE;
            cnt_d   = STB_LOAD;
          end else if (cnt_q == '0) begin
            retry_d = retry_inc;
            if (retry_inc == RETRY_LIM) begin
              state_d = S_FAULT;
            end else begin
              state_d = S_RESET_PLL;
              cnt_d   = RST_LOAD;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_STABLE: begin
          if (!lock_s_q) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = TO_LOAD;
          end else if (cnt_q == '0) begin
            state_d = S_RUN;
            retry_d = 4'd0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_RUN: begin
          if (!lock_s_q) begin
            state_d = S_RESET_PLL;
            cnt_d   = RST_LOAD;
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_RESET_PLL;
          cnt_d   = RST_LOAD;
        end
      endcase
    end
  end

  // Outputs are registered and decoded from the next state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= RST_LOAD;
      retry_q     <= 4'd0;
      sync1_q     <= 1'b0;
      lock_s_q    <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      sync1_q     <= pll_locked;
      lock_s_q    <= sync1_q;
      pll_rst_q   <= (state_d == S_RESET_PLL) || (state_d == S_FAULT);
      sys_reset_q <= (state_d != S_RUN);
      ready_q     <= (state_d == S_RUN);
      fault_q     <= (state_d == S_FAULT);
    end
  end

`ifdef PLL_SEQ_LOCK_LOSS_COUNTER_EN
  logic [7:0] loss_q;
  logic       loss_evt;

  assign loss_evt = (state_q == S_RUN) && !lock_s_q && !relock_req;

  always_ff @(posedge refclk) begin
    if (rst) begin
      loss_q <= 8'd0;
    end else if (loss_evt && (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign lock_loss_count = loss_q;
`else
  assign lock_loss_count = 8'd0;
`endif

  assign pll_rst     = pll_rst_q;
  assign sys_reset   = sys_reset_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_nios2_system_v0_pll_reset_sequencer.sv
// Bench for the PLL reset sequencer: directed timing scenarios plus randomized lock/relock/reset traffic
// checked every cycle against a phase/elapsed-time reference model.
module tb_nios2_system_v0_pll_reset_sequencer;

  localparam int RP  = 4;
  localparam int LS  = 8;
  localparam int TO  = 32;
  localparam int MR  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst, sys_reset, ready, fault;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_count;

  int n_tests = 0;
  int n_fail  = 0;

  nios2_system_v0_pll_reset_sequencer #(
    .RST_PULSE_CYCLES   (RP),
    .LOCK_STABLE_CYCLES (LS),
    .LOCK_TIMEOUT_CYCLES(TO),
    .MAX_RETRIES        (MR)
  ) dut (
    .refclk         (clk),
    .rst            (rst),
    .pll_locked     (pll_locked),
    .relock_req     (relock_req),
    .pll_rst        (pll_rst),
    .sys_reset      (sys_reset),
    .ready          (ready),
    .fault          (fault),
    .retry_count    (retry_count),
    .lock_loss_count(lock_loss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: named phases, time spent in the current phase, and a two-deep history of raw lock.
  localparam int P_RESET = 0, P_WAIT = 1, P_STABLE = 2, P_RUN = 3, P_FAULT = 4;
  int m_phase = P_RESET;
  int m_elapsed = 0;
  int m_retry = 0;
  int m_loss = 0;
  bit m_hist[2] = '{1'b0, 1'b0};

  task automatic model_edge();
    bit seen;
    seen = m_hist[1];
    if (rst) begin
      m_phase = P_RESET; m_elapsed = 0; m_retry = 0; m_loss = 0;
      m_hist[0] = 1'b0; m_hist[1] = 1'b0;
      return;
    end
    m_hist[1] = m_hist[0];
    m_hist[0] = pll_locked;
    if (relock_req) begin
      m_phase = P_RESET; m_elapsed = 0; m_retry = 0;
      return;
    end
    case (m_phase)
      P_RESET: begin
        m_elapsed++;
        if (m_elapsed == RP) begin m_phase = P_WAIT; m_elapsed = 0; end
      end
      P_WAIT: begin
        if (seen) begin
          m_phase = P_STABLE; m_elapsed = 0;
        end else begin
          m_elapsed++;
          if (m_elapsed == TO) begin
            m_retry++;
            m_phase = (m_retry == MR) ? P_FAULT : P_RESET;
            m_elapsed = 0;
          end
        end
      end
      P_STABLE: begin
        if (!seen) begin
          m_phase = P_WAIT; m_elapsed = 0;
        end else begin
          m_elapsed++;
          if (m_elapsed == LS) begin m_phase = P_RUN; m_retry = 0; end
        end
      end
      P_RUN: begin
        if (!seen) begin
          m_phase = P_RESET; m_elapsed = 0;
          if (m_loss < 255) m_loss++;
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [15:0] model_outs();
    logic [7:0] loss;
`ifdef PLL_SEQ_LOCK_LOSS_COUNTER_EN
    loss = 8'(m_loss);
`else
    loss = 8'd0;
`endif
    return {(m_phase == P_RESET) || (m_phase == P_FAULT), m_phase != P_RUN,
            m_phase == P_RUN, m_phase == P_FAULT, 4'(m_retry), loss};
  endfunction

  function automatic logic [15:0] dut_outs();
    return {pll_rst, sys_reset, ready, fault, retry_count, lock_loss_count};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("cycle", 32'(dut_outs()), 32'(model_outs()));
  endtask

  initial begin
    int k;
    int n;
    int seg;
    bit lvl;

    // Reset state
    repeat (2) step();
    chk("reset_outs", 32'(dut_outs()), 32'h0000_C000);

    // Nominal: pll_rst pulse width, then lock-to-release latency
    rst = 1'b0;
    n = 1;
    for (k = 1; k <= 20; k++) begin
      step();
      if (!pll_rst) break;
      n++;
    end
    chk("rst_pulse_len", 32'(n), 32'(RP));
    repeat (6) step();
    pll_locked = 1'b1;
    for (k = 1; k <= 40; k++) begin step(); if (!sys_reset) break; end
    chk("nom_release_lat", 32'(k), 32'd11);
    chk("nom_ready_retry", 32'({ready, retry_count}), 32'h10);

    // Glitch in STABLE after 5 stable cycles: full count restarts
    relock_req = 1'b1; step(); relock_req = 1'b0;
    repeat (8) step();
    pll_locked = 1'b0; step(); pll_locked = 1'b1;
    for (k = 1; k <= 40; k++) begin step(); if (!sys_reset) break; end
    chk("glitch_release_lat", 32'(k), 32'd11);

    // Lock loss in RUN, then repeated timeouts into FAULT
    pll_locked = 1'b0;
    for (k = 1; k <= 10; k++) begin step(); if (sys_reset) break; end
    chk("lockloss_lat", 32'(k), 32'd3);
`ifdef PLL_SEQ_LOCK_LOSS_COUNTER_EN
    chk("lockloss_count", 32'(lock_loss_count), 32'd1);
`else
    chk("lockloss_count", 32'(lock_loss_count), 32'd0);
`endif
    for (k = 1; k <= 200; k++) begin step(); if (fault) break; end
    chk("fault_lat", 32'(k), 32'd72);
    chk("fault_outs", 32'({fault, pll_rst, retry_count}), 32'b11_0010);

    // Recovery from FAULT
    relock_req = 1'b1; step(); relock_req = 1'b0;
    chk("recover_outs", 32'({fault, pll_rst, retry_count}), 32'b01_0000);
    pll_locked = 1'b1;
    for (k = 1; k <= 40; k++) begin step(); if (ready) break; end
    chk("recover_ready_lat", 32'(k), 32'd13);

    // rst for one cycle in STABLE, then full restart
    relock_req = 1'b1; step(); relock_req = 1'b0;
    repeat (6) step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("midreset_outs", 32'(dut_outs()), 32'h0000_C000);
    for (k = 1; k <= 40; k++) begin step(); if (ready) break; end
    chk("midreset_ready_lat", 32'(k), 32'd13);

    // Randomized traffic against the model
    seg = 0;
    lvl = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (seg == 0) begin
        lvl = ($urandom_range(0, 3) != 0);
        seg = $urandom_range(1, 80);
      end
      pll_locked = lvl;
      seg--;
      relock_req = ($urandom_range(0, 199) == 0);
      rst        = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    relock_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nios2_system_v0_pll_reset_sequencer.md
# nios2_system_v0_pll_reset_sequencer

Reset and lock sequencer for the system PLL (50 MHz reference in, 200 MHz out). Runs on the free-running reference clock, drives the PLL reset, qualifies the PLL lock indication, and releases the downstream system reset only after lock has been stable for a programmable interval. It retries on lock timeout, re-sequences on loss of lock, and flags a fault after repeated failures.

## Interface
Parameters:
- RST_PULSE_CYCLES, 16: cycles `pll_rst` is held high per reset attempt (≥1).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release (≥1).
- LOCK_TIMEOUT_CYCLES, 65536: maximum cycles in WAIT_LOCK per attempt (≥1).
- MAX_RETRIES, 3: consecutive timeouts that cause FAULT (1..15).

Ports:
- refclk  in  1  free-running 50 MHz reference clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  raw PLL lock output, asynchronous to `refclk`.
- relock_req  in  1  single-cycle request to restart the full sequence.
- pll_rst  out  1  reset to PLL `rst` input.
- sys_reset  out  1  active-high reset to the 200 MHz domain's reset synchronizer.
- ready  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- retry_count  out  4  consecutive lock timeouts in the current sequence.
- lock_loss_count  out  8  see Configuration.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to form `lock_s`; only `lock_s` is used.
- States: RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT. One shared down-counter; width = clog2 of largest parameter + 1.
- RESET_PLL: `pll_rst`=1, `sys_reset`=1. After RST_PULSE_CYCLES cycles → WAIT_LOCK.
- WAIT_LOCK: `pll_rst`=0, `sys_reset`=1. If `lock_s`=1 → STABLE (counter loaded). If LOCK_TIMEOUT_CYCLES elapse without lock: `retry_count`+1; if the new value equals MAX_RETRIES → FAULT, else → RESET_PLL.
- STABLE: `sys_reset`=1. `lock_s`=0 → WAIT_LOCK, with timeout restarted and `retry_count` unchanged. After LOCK_STABLE_CYCLES consecutive `lock_s`=1 → RUN, with `retry_count` cleared.
- RUN: `pll_rst`=0, `sys_reset`=0, `ready`=1. `lock_s`=0 → RESET_PLL; `sys_reset` reasserts on the same edge.
- FAULT: `pll_rst`=1, `sys_reset`=1, `fault`=1. Held until `rst` or `relock_req`.
- `relock_req` in any state → RESET_PLL, with `retry_count`=0 and `fault`=0. It overrides every other transition in the same cycle.
- Outputs are registered, decoded from next-state.

## Timing
- Reset values on the `rst` edge: state RESET_PLL, `pll_rst`=1, `sys_reset`=1, `ready`=0, `fault`=0, `retry_count`=0, `lock_loss_count`=0, synchronizer flops 0.
- `rst` asserted mid-sequence returns all outputs to reset values at the next edge. The reset-pulse count starts on the first cycle with `rst`=0.
- `pll_rst` stays high exactly RST_PULSE_CYCLES cycles after reset release or re-entry.
- Raw lock to `lock_s`: 2 cycles. `lock_s` rising to `sys_reset` falling: LOCK_STABLE_CYCLES+1 cycles.
- RUN lock-loss response: `pll_locked` falling to `sys_reset` high takes 3 cycles (2 synchronizer + 1 register).
- A timeout and `lock_s` rising in the same cycle resolve as lock → STABLE.

## Configuration
- Macro: PLL_SEQ_LOCK_LOSS_COUNTER_EN.
- Defined: `lock_loss_count` increments on each RUN→RESET_PLL transition caused by lock loss, saturates at 255, and clears only on `rst`.
- Undefined: no counter logic is built, and `lock_loss_count` is tied to 0.

## Test plan
Bench parameters: RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
- Nominal: release `rst`, raise `pll_locked` 10 cycles later and hold → `pll_rst` high for 4 cycles, `sys_reset` falls 11 cycles after the `pll_locked` rise, `ready`=1, `retry_count`=0.
- Glitch in STABLE: lock drops for 1 cycle after 5 stable cycles → back to WAIT_LOCK, full 8-cycle count restarts, then RUN.
- Timeout/fault: hold `pll_locked`=0 → `retry_count` goes 1 after the first 32-cycle timeout, then 2 → FAULT; `fault`=1, `pll_rst`=1.
- Recovery: `relock_req` pulse in FAULT → `fault`=0, `retry_count`=0, 4-cycle `pll_rst` pulse, normal lock to RUN.
- Lock loss in RUN: drop `pll_locked` → `sys_reset`=1 three cycles later, new `pll_rst` pulse. With the macro defined, `lock_loss_count`=1.
- Reset mid-STABLE: assert `rst` for 1 cycle → all outputs at reset values on the next edge, and the sequence restarts.
